// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam int unsigned KEY_LEN = 9;

    typedef logic [7:0] key_t [KEY_LEN];

    // "TEKNOFEST"
    localparam key_t KEY = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F,
                             8'h46, 8'h45, 8'h53, 8'h54};

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit validation,
// mid-bit sampling and stop-bit check.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        state;
    logic [1:0]       sync;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign rx_s = sync[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= RX_IDLE;
            sync         <= 2'b11;
            rx_prev      <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            sync         <= {sync[0], rx_i};
            rx_prev      <= rx_s;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    // Arm only on a genuine falling edge so a low line after a
                    // bad stop bit does not retrigger.
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            byte_o       <= shreg;
                            byte_valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: matches the "TEKNOFEST" key on the programming UART, then
// streams a length-prefixed little-endian image into main memory from address 0.
module program_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              program_rx_i,
    output logic              prog_mode_o,
    output logic              core_rst_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              done_o,
    output logic              err_o
);

    import program_loader_pkg::*;

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;

    state_t            state;
    logic [3:0]        key_idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_sr;
    logic [31:0]       word_next;
    logic [31:0]       remaining;
    logic              buf_valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              prog_mode;
    logic              done;
    logic              err;
    logic              word_done;
    logic              handshake;
    logic              last_hs;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (program_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr)
    );

    always_comb begin
        word_next = {rx_byte, word_sr[31:8]};
        word_done = rx_valid && (byte_cnt == 2'd3);
        handshake = buf_valid && mem_ready_i;
        last_hs   = handshake && (remaining == 32'd1);
    end

    assign prog_mode_o = prog_mode;
    assign core_rst_o  = prog_mode;
    assign mem_we_o    = buf_valid;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = wdata;
    assign done_o      = done;
    assign err_o       = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            key_idx   <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            remaining <= '0;
            buf_valid <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            prog_mode <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_ferr) begin
                        key_idx <= '0;
                    end else if (rx_valid) begin
                        if (rx_byte == KEY[key_idx]) begin
                            if (key_idx == 4'(KEY_LEN - 1)) begin
                                state     <= ST_LEN;
                                key_idx   <= '0;
                                byte_cnt  <= '0;
                                err       <= 1'b0;
                                addr      <= '0;
                                prog_mode <= 1'b1;
                            end else begin
                                key_idx <= key_idx + 4'd1;
                            end
                        end else begin
                            key_idx <= (rx_byte == KEY[0]) ? 4'd1 : 4'd0;
                        end
                    end
                end
                ST_LEN: begin
                    if (rx_ferr) begin
                        err       <= 1'b1;
                        prog_mode <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (rx_valid) begin
                        word_sr  <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            remaining <= word_next;
                            if (word_next == '0) begin
                                done      <= 1'b1;
                                prog_mode <= 1'b0;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr || (word_done && buf_valid && !mem_ready_i)) begin
                        err       <= 1'b1;
                        buf_valid <= 1'b0;
                        prog_mode <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (rx_valid) begin
                            word_sr  <= word_next;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                        if (handshake) begin
                            buf_valid <= 1'b0;
                            addr      <= addr + ADDR_W'(1);
                            remaining <= remaining - 32'd1;
                            if (last_hs) begin
                                done      <= 1'b1;
                                prog_mode <= 1'b0;
                                state     <= ST_DONE;
                            end
                        end
                        // A word landing with a handshake reloads the buffer in place.
                        if (word_done && !last_hs) begin
                            buf_valid <= 1'b1;
                            wdata     <= word_next;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes,
// a negedge monitor pops them on each memory handshake.
module tb_program_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          ready;
    logic          prog_mode;
    logic          core_rst;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          done;
    logic          err;

    wr_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  hs_count  = 0;
    int  done_seen = 0;
    int  exp_done  = 0;

    logic [7:0] key_b [9] = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F,
                              8'h46, 8'h45, 8'h53, 8'h54};

    always #5 clk = ~clk;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .program_rx_i(rx),
        .prog_mode_o (prog_mode),
        .core_rst_o  (core_rst),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (ready),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t w;
        if (!rst) begin
            check("core_rst_eq_prog", {31'd0, core_rst}, {31'd0, prog_mode});
            if (mem_we && ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", {16'd0, mem_addr}, {16'd0, w.addr});
                    check("wr_data", mem_wdata, w.data);
                end
            end
            if (done) begin
                done_seen++;
                check("prog_low_at_done", {31'd0, prog_mode}, 32'd0);
                check("err_low_at_done", {31'd0, err}, 32'd0);
                check("writes_pending_at_done", exp_q.size(), 32'd0);
                if (exp_done == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done pulse expected none");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_key();
        for (int i = 0; i < 9; i++) send_byte(key_b[i], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, done_seen, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_prog", {31'd0, prog_mode}, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Normal load of two words
        send_key();
        check("s1_prog_after_key", {31'd0, prog_mode}, 32'd1);
        exp_q.push_back('{addr: 16'h0000, data: 32'h0000_0013});
        exp_q.push_back('{addr: 16'h0001, data: 32'h0010_0093});
        exp_done++;
        send_word(32'd2);
        check("s1_prog_in_data", {31'd0, prog_mode}, 32'd1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_done(1, "s1_done");
        check("s1_prog_after", {31'd0, prog_mode}, 32'd0);
        check("s1_we_after", {31'd0, mem_we}, 32'd0);

        // Partial key restart, then zero length
        hs_before = hs_count;
        send_byte(8'h54, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h4B, 1'b1);
        send_key();
        check("s2_prog_after_key", {31'd0, prog_mode}, 32'd1);
        exp_done++;
        send_word(32'd0);
        wait_done(2, "s2_done");
        check("s2_no_writes", hs_count, hs_before);
        check("s2_prog_after", {31'd0, prog_mode}, 32'd0);

        // Backpressure on word 0
        send_key();
        send_word(32'd2);
        exp_q.push_back('{addr: 16'h0000, data: 32'hDEAD_BEEF});
        exp_q.push_back('{addr: 16'h0001, data: 32'h1122_3344});
        exp_done++;
        ready = 1'b0;
        send_word(32'hDEAD_BEEF);
        check("s3_we_held", {31'd0, mem_we}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("s3_hold_we", {31'd0, mem_we}, 32'd1);
            check("s3_hold_addr", {16'd0, mem_addr}, 32'd0);
            check("s3_hold_data", mem_wdata, 32'hDEAD_BEEF);
        end
        ready = 1'b1;
        send_word(32'h1122_3344);
        wait_done(3, "s3_done");
        check("s3_no_err", {31'd0, err}, 32'd0);

        // Overrun: two words with memory never ready
        send_key();
        send_word(32'd2);
        hs_before = hs_count;
        ready = 1'b0;
        send_word(32'hAAAA_0001);
        send_word(32'hAAAA_0002);
        check("s4_err", {31'd0, err}, 32'd1);
        check("s4_prog", {31'd0, prog_mode}, 32'd0);
        check("s4_we", {31'd0, mem_we}, 32'd0);
        check("s4_no_handshake", hs_count, hs_before);
        ready = 1'b1;
        repeat (5) @(negedge clk);
        check("s4_still_no_handshake", hs_count, hs_before);

        // Framing error on 2nd data byte, then a clean reload
        send_key();
        check("s5_err_cleared_by_key", {31'd0, err}, 32'd0);
        send_word(32'd1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        check("s5_err", {31'd0, err}, 32'd1);
        check("s5_prog", {31'd0, prog_mode}, 32'd0);
        send_key();
        check("s5_err_cleared", {31'd0, err}, 32'd0);
        check("s5_prog_reload", {31'd0, prog_mode}, 32'd1);
        exp_q.push_back('{addr: 16'h0000, data: 32'hCAFE_F00D});
        exp_done++;
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        wait_done(4, "s5_done");

        // Reset mid-load with a write pending
        send_key();
        send_word(32'd2);
        ready = 1'b0;
        send_word(32'h0BAD_0BAD);
        check("s6_we_before_rst", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("s6_async_prog", {31'd0, prog_mode}, 32'd0);
        check("s6_async_core_rst", {31'd0, core_rst}, 32'd0);
        check("s6_async_we", {31'd0, mem_we}, 32'd0);
        check("s6_async_wdata", mem_wdata, 32'd0);
        check("s6_async_addr", {16'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        hs_before = hs_count;
        repeat (3) @(negedge clk);
        send_word(32'h1234_5678);
        check("s6_ignored_prog", {31'd0, prog_mode}, 32'd0);
        check("s6_ignored_writes", hs_count, hs_before);
        check("s6_no_done", done_seen, 32'd4);

        check("final_writes_outstanding", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader between the board's dedicated programming UART line and the main memory write port. It deserialises bytes from `program_rx_i` and watches for the ASCII key "TEKNOFEST". It then receives a 32-bit word count followed by the program image, and writes it word by word into main memory from word address 0. While loading, it holds the core in reset and drives the program-mode LED.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `ADDR_W`, 16: main-memory word-address width.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `program_rx_i`  in  1  programming UART line, idle high, 8N1, LSB first.
- `prog_mode_o`  out  1  high while a load is in progress; drives the LED.
- `core_rst_o`  out  1  core reset request; equal to `prog_mode_o`.
- `mem_we_o`  out  1  memory write request.
- `mem_addr_o`  out  ADDR_W  word address.
- `mem_wdata_o`  out  32  write data.
- `mem_ready_i`  in  1  memory accepts the write when `mem_we_o & mem_ready_i`.
- `done_o`  out  1  one-cycle pulse on successful completion.
- `err_o`  out  1  sticky error flag; cleared on the next key match.

## Operation
- **UART receiver**
  - `program_rx_i` passes through a 2-FF synchroniser.
  - A falling edge in idle arms the receiver. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the receiver returns to idle.
  - 8 data bits are sampled at bit centres.
  - Stop bit: if it reads 1, the receiver emits `byte_valid` for one cycle. If it reads 0, it emits `frame_err` for one cycle and no byte.
- **FSM states:** IDLE, LEN, DATA, DONE.
- **IDLE (key matching)**
  - A match index 0..8 tracks progress against the key.
  - Byte equal to the expected key byte: index increments.
  - Mismatch: index becomes 1 if the byte is 'T', else 0. `frame_err` clears the index to 0.
  - Index reaching 9: go to LEN, clear `err_o`, clear the address to 0, raise `prog_mode_o`.
- **LEN**
  - Assemble 4 bytes little-endian into `count` (32 bits).
  - `count == 0`: go to DONE. Otherwise go to DATA.
- **DATA**
  - Assemble 4 bytes little-endian into a word.
  - On the 4th byte, load the one-entry write buffer (`mem_we_o` = buffer valid).
  - On handshake, clear the buffer, increment the address (wraps modulo 2^ADDR_W), and decrement the remaining count.
  - When the remaining count reaches 0 with the buffer empty, go to DONE.
- **DONE:** pulse `done_o`, drop `prog_mode_o`, return to IDLE.
- **Errors:** a `frame_err` in LEN or DATA, or a word completing while the buffer is still valid (overrun), sets `err_o`, drops `mem_we_o` and `prog_mode_o`, and returns to IDLE. Words already written are not undone.
- Bytes arriving in IDLE never write memory.

## Timing
- **Reset values:** all outputs 0; address 0; FSM IDLE; receiver idle.
- **Receive latency:** `byte_valid` rises 2 cycles (synchroniser) plus (9.5 × CLKS_PER_BIT) cycles after the start-bit falling edge, ±1 cycle.
- **Program mode:** `prog_mode_o`/`core_rst_o` go high on the cycle after the byte_valid of the final 'T'.
- **Write request:** `mem_we_o` goes high on the cycle after the byte_valid of each word's 4th byte. Address and data are stable until the handshake. `mem_we_o` drops on the cycle after the handshake unless a new word is already complete.
- **Completion:** `done_o` pulses on the cycle after the final handshake, or on the cycle after the 4th length byte when N = 0; `prog_mode_o` falls on that same edge.
- **Simultaneous events:** a handshake and a new word completing on the same cycle is not an overrun; the buffer reloads.
- **Reset mid-load:** immediate return to reset values. The partial image is left in memory.

## Structure
- Package `program_loader_pkg`: FSM state enum, `KEY_LEN = 9`, and the key byte array "TEKNOFEST".
- Sub-module `uart_rx_byte` (parameter CLKS_PER_BIT; outputs `byte_o`, `byte_valid_o`, `frame_err_o`) contains the synchroniser, bit counter and baud counter.
- The top level holds the key matcher, FSM, byte/word assembler and write buffer.

## Test plan
All scenarios use CLKS_PER_BIT=4 and `mem_ready_i`=1 unless stated.
- **Normal load:** key, length 02 00 00 00, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 at address 0 and 0x00100093 at address 1; then one `done_o` pulse; `prog_mode_o` high from after the final 'T' until `done_o`.
- **Partial key restart:** "TEKTEKNOFEST" then length 0 -> `prog_mode_o` goes high; `done_o` pulses after the 4th length byte; no memory writes.
- **Backpressure:** `mem_ready_i` low for 50 cycles during word 0 -> `mem_we_o`, address and data held; write completes once ready rises; no error.
- **Overrun:** `mem_ready_i` held low across two full words -> `err_o`=1; `prog_mode_o`=0; FSM in IDLE; exactly zero handshakes.
- **Framing error:** stop bit driven 0 on the 2nd data byte -> `err_o`=1 and IDLE. A following valid load clears `err_o` and succeeds.
- **Reset mid-load:** `rst_i` pulsed while in DATA -> all outputs 0 asynchronously. The bytes that follow are ignored until a new key.
